// File: rtl/gen_buffer_controller_pkg.sv
// Shared types for the ping-pong bank controller.
// Holds the FSM state encoding and bank select constants.
package gol_buf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT_SWAP,
    SWAP
  } state_t;

  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

endpackage

// File: rtl/gen_buffer_controller_if.sv
// One true-dual-port BRAM bank: port a and port b bundles.
// master = controller side, slave = BRAM side.
interface gen_buffer_controller_if #(
  parameter int X_SIZE  = 1280,
  parameter int Y_WIDTH = 10
);

  logic [Y_WIDTH-1:0] addra;
  logic [X_SIZE-1:0]  dina;
  logic               wea;
  logic [X_SIZE-1:0]  douta;
  logic [Y_WIDTH-1:0] addrb;
  logic [X_SIZE-1:0]  dinb;
  logic               web;
  logic [X_SIZE-1:0]  doutb;

  modport master (
    output addra, dina, wea,
    output addrb, dinb, web,
    input  douta, doutb
  );

  modport slave (
    input  addra, dina, wea,
    input  addrb, dinb, web,
    output douta, doutb
  );

endinterface

// File: rtl/gen_buffer_controller_router.sv
// Combinational steering of both BRAM banks from front select.
// Front bank serves fetch (port a) and video (port b); back takes writes.
module bank_router
  import gol_buf_pkg::*;
#(
  parameter int X_SIZE  = 1280,
  parameter int Y_WIDTH = 10
) (
  input  logic               front,
  input  logic               we_q,
  input  logic [Y_WIDTH-1:0] fetch_addr,
  input  logic [Y_WIDTH-1:0] wr_addr,
  input  logic [X_SIZE-1:0]  wr_data,
  input  logic [Y_WIDTH-1:0] vid_addr,
  output logic [X_SIZE-1:0]  fetch_data,
  output logic [X_SIZE-1:0]  vid_data,
  output logic [Y_WIDTH-1:0] a_addra,
  output logic [X_SIZE-1:0]  a_dina,
  output logic               a_wea,
  output logic [Y_WIDTH-1:0] a_addrb,
  output logic [X_SIZE-1:0]  a_dinb,
  output logic               a_web,
  input  logic [X_SIZE-1:0]  a_douta,
  input  logic [X_SIZE-1:0]  a_doutb,
  output logic [Y_WIDTH-1:0] b_addra,
  output logic [X_SIZE-1:0]  b_dina,
  output logic               b_wea,
  output logic [Y_WIDTH-1:0] b_addrb,
  output logic [X_SIZE-1:0]  b_dinb,
  output logic               b_web,
  input  logic [X_SIZE-1:0]  b_douta,
  input  logic [X_SIZE-1:0]  b_doutb
);

  assign a_addrb = vid_addr;
  assign b_addrb = vid_addr;
  assign a_dinb  = '0;
  assign b_dinb  = '0;
  assign a_web   = 1'b0;
  assign b_web   = 1'b0;

  always_comb begin
    a_addra    = fetch_addr;
    a_dina     = '0;
    a_wea      = 1'b0;
    b_addra    = wr_addr;
    b_dina     = wr_data;
    b_wea      = we_q;
    fetch_data = a_douta;
    vid_data   = a_doutb;
    if (front == BANK_B) begin
      a_addra    = wr_addr;
      a_dina     = wr_data;
      a_wea      = we_q;
      b_addra    = fetch_addr;
      b_dina     = '0;
      b_wea      = 1'b0;
      fetch_data = b_douta;
      vid_data   = b_doutb;
    end
  end

endmodule

// File: rtl/gen_buffer_controller.sv
// Ping-pong bank controller: sequences generations, swaps at frame end.
// Ports: pause/step/frame_end control, gen_start/gen_done handshake,
// fetch/wr/vid row ports, two BRAM bank bundles, front/gen_count/wr_oob.
module gen_buffer_controller
  import gol_buf_pkg::*;
#(
  parameter int X_SIZE    = 1280,
  parameter int Y_SIZE    = 720,
  parameter int Y_WIDTH   = 10,
  parameter int GEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pause,
  input  logic                 step,
  input  logic                 frame_end,
  output logic                 gen_start,
  input  logic                 gen_done,
  input  logic [Y_WIDTH-1:0]   fetch_addr,
  output logic [X_SIZE-1:0]    fetch_data,
  input  logic [Y_WIDTH-1:0]   wr_addr,
  input  logic [X_SIZE-1:0]    wr_data,
  input  logic                 wr_en,
  input  logic [Y_WIDTH-1:0]   vid_addr,
  output logic [X_SIZE-1:0]    vid_data,
  output logic                 front,
  output logic [GEN_WIDTH-1:0] gen_count,
  output logic                 wr_oob,
  gen_buffer_controller_if.master bram_a,
  gen_buffer_controller_if.master bram_b
);

  // One extra bit so Y_SIZE == 2**Y_WIDTH still compares correctly.
  localparam logic [Y_WIDTH:0] Y_LIM = (Y_WIDTH+1)'(Y_SIZE);

  state_t state;
  state_t state_nx;
  logic   start_nx;
  logic   in_range;
  logic   we_q;

  assign in_range = {1'b0, wr_addr} < Y_LIM;
  assign we_q     = wr_en && in_range && (state == RUN);

  always_comb begin
    state_nx = state;
    start_nx = 1'b0;
    unique case (state)
      IDLE: begin
        if (!pause || step) begin
          state_nx = RUN;
          start_nx = 1'b1;
        end
      end
      RUN: begin
        if (gen_done)
          state_nx = frame_end ? SWAP : WAIT_SWAP;
      end
      WAIT_SWAP: begin
        if (frame_end)
          state_nx = SWAP;
      end
      SWAP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gen_start <= 1'b0;
      front     <= BANK_A;
      gen_count <= '0;
      wr_oob    <= 1'b0;
    end else begin
      state     <= state_nx;
      gen_start <= start_nx;
      if (state == SWAP) begin
        front     <= ~front;
        gen_count <= gen_count + 1'b1;
      end
      if (wr_en && !in_range)
        wr_oob <= 1'b1;
    end
  end

  bank_router #(
    .X_SIZE (X_SIZE),
    .Y_WIDTH(Y_WIDTH)
  ) u_router (
    .front     (front),
    .we_q      (we_q),
    .fetch_addr(fetch_addr),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .vid_addr  (vid_addr),
    .fetch_data(fetch_data),
    .vid_data  (vid_data),
    .a_addra   (bram_a.addra),
    .a_dina    (bram_a.dina),
    .a_wea     (bram_a.wea),
    .a_addrb   (bram_a.addrb),
    .a_dinb    (bram_a.dinb),
    .a_web     (bram_a.web),
    .a_douta   (bram_a.douta),
    .a_doutb   (bram_a.doutb),
    .b_addra   (bram_b.addra),
    .b_dina    (bram_b.dina),
    .b_wea     (bram_b.wea),
    .b_addrb   (bram_b.addrb),
    .b_dinb    (bram_b.dinb),
    .b_web     (bram_b.web),
    .b_douta   (bram_b.douta),
    .b_doutb   (bram_b.doutb)
  );

endmodule

// File: tb/tb_gen_buffer_controller.sv
// Directed bench for gen_buffer_controller with 1-cycle BRAM models.
// Scenario tasks run in sequence; each checks its own expectations.
module tb_gen_buffer_controller;

  localparam int XS = 1280;
  localparam int YW = 10;
  localparam int GW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          pause;
  logic          step;
  logic          frame_end;
  logic          gen_start;
  logic          gen_done;
  logic [YW-1:0] fetch_addr;
  logic [XS-1:0] fetch_data;
  logic [YW-1:0] wr_addr;
  logic [XS-1:0] wr_data;
  logic          wr_en;
  logic [YW-1:0] vid_addr;
  logic [XS-1:0] vid_data;
  logic          front;
  logic [GW-1:0] gen_count;
  logic          wr_oob;

  int total = 0;
  int bad = 0;

  gen_buffer_controller_if #(.X_SIZE(XS), .Y_WIDTH(YW)) ifa ();
  gen_buffer_controller_if #(.X_SIZE(XS), .Y_WIDTH(YW)) ifb ();

  logic [XS-1:0] mem_a [0:1023];
  logic [XS-1:0] mem_b [0:1023];

  always @(posedge clk) begin
    if (ifa.wea) mem_a[ifa.addra] <= ifa.dina;
    ifa.douta <= mem_a[ifa.addra];
    ifa.doutb <= mem_a[ifa.addrb];
  end

  always @(posedge clk) begin
    if (ifb.wea) mem_b[ifb.addra] <= ifb.dina;
    ifb.douta <= mem_b[ifb.addra];
    ifb.doutb <= mem_b[ifb.addrb];
  end

  always #5 clk = ~clk;

  gen_buffer_controller #(
    .X_SIZE(XS), .Y_SIZE(720),
    .Y_WIDTH(YW), .GEN_WIDTH(GW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pause     (pause),
    .step      (step),
    .frame_end (frame_end),
    .gen_start (gen_start),
    .gen_done  (gen_done),
    .fetch_addr(fetch_addr),
    .fetch_data(fetch_data),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .vid_addr  (vid_addr),
    .vid_data  (vid_data),
    .front     (front),
    .gen_count (gen_count),
    .wr_oob    (wr_oob),
    .bram_a    (ifa),
    .bram_b    (ifb)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp_v);
    end
  endtask

  // Write rows 0..n-1 with data row+off; report front-bank wea activity.
  task automatic write_rows(input int n, input int off,
                            input logic efront,
                            output logic front_we);
    front_we = 1'b0;
    for (int r = 0; r < n; r++) begin
      wr_addr = YW'(r);
      wr_data = XS'(r + off);
      wr_en   = 1'b1;
      #1;
      if ((efront ? ifb.wea : ifa.wea) !== 1'b0) front_we = 1'b1;
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pause = 1'b0;
    step = 1'b0;
    frame_end = 1'b0;
    gen_done = 1'b0;
    fetch_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    wr_en = 1'b0;
    vid_addr = '0;
    tick();
    tick();
    total++;
    if (front !== 1'b0) begin
      bad++; $display("FAIL rst_front: got %b want 0", front);
    end
    total++;
    if (gen_start !== 1'b0) begin
      bad++; $display("FAIL rst_start: got %b want 0", gen_start);
    end
    total++;
    if (gen_count !== 16'd0) begin
      bad++; $display("FAIL rst_count: got %0d want 0", gen_count);
    end
    total++;
    if (wr_oob !== 1'b0) begin
      bad++; $display("FAIL rst_oob: got %b want 0", wr_oob);
    end
    total++;
    if ({ifa.wea, ifb.wea, ifa.web, ifb.web} !== 4'b0) begin
      bad++;
      $display("FAIL rst_we: got %b want 0000",
               {ifa.wea, ifb.wea, ifa.web, ifb.web});
    end
  endtask

  task automatic test_free_run();
    logic fwe;
    rst = 1'b0;
    tick();
    total++;
    if (gen_start !== 1'b1) begin
      bad++; $display("FAIL start_c1: got %b want 1", gen_start);
    end
    write_rows(720, 0, 1'b0, fwe);
    total++;
    if (fwe !== 1'b0) begin
      bad++; $display("FAIL front_we_g1: got %b want 0", fwe);
    end
    total++;
    if (mem_b[719] !== XS'(719)) begin
      bad++; $display("FAIL back_row719: got %0d want 719", mem_b[719]);
    end
    gen_done = 1'b1;
    tick();
    gen_done = 1'b0;
    // Now WAIT_SWAP: writes must be blocked.
    wr_addr = 10'd3;
    wr_data = XS'(999);
    wr_en = 1'b1;
    #1;
    total++;
    if (ifb.wea !== 1'b0) begin
      bad++; $display("FAIL wait_wea: got %b want 0", ifb.wea);
    end
    tick();
    tick();
    wr_en = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    total++;
    if (front !== 1'b0) begin
      bad++; $display("FAIL front_in_swap: got %b want 0", front);
    end
    tick();
    total++;
    if (front !== 1'b1) begin
      bad++; $display("FAIL front_g1: got %b want 1", front);
    end
    total++;
    if (gen_count !== 16'd1) begin
      bad++; $display("FAIL count_g1: got %0d want 1", gen_count);
    end
    total++;
    if (gen_start !== 1'b0) begin
      bad++; $display("FAIL start_early: got %b want 0", gen_start);
    end
    total++;
    if (mem_b[3] !== XS'(3)) begin
      bad++; $display("FAIL wait_block: got %0d want 3", mem_b[3]);
    end
    vid_addr = 10'd5;
    fetch_addr = 10'd7;
    tick();
    total++;
    if (gen_start !== 1'b1) begin
      bad++; $display("FAIL restart: got %b want 1", gen_start);
    end
    total++;
    if (vid_data !== XS'(5)) begin
      bad++; $display("FAIL vid_row5: got %0d want 5", vid_data);
    end
    total++;
    if (fetch_data !== XS'(7)) begin
      bad++; $display("FAIL fetch_row7: got %0d want 7", fetch_data);
    end
  endtask

  task automatic test_same_cycle();
    logic fwe;
    pause = 1'b1;
    write_rows(8, 100, 1'b1, fwe);
    total++;
    if (fwe !== 1'b0) begin
      bad++; $display("FAIL front_we_g2: got %b want 0", fwe);
    end
    gen_done = 1'b1;
    frame_end = 1'b1;
    tick();
    gen_done = 1'b0;
    frame_end = 1'b0;
    tick();
    total++;
    if (front !== 1'b0) begin
      bad++; $display("FAIL same_front: got %b want 0", front);
    end
    total++;
    if (gen_count !== 16'd2) begin
      bad++; $display("FAIL same_count: got %0d want 2", gen_count);
    end
    fetch_addr = 10'd4;
    tick();
    total++;
    if (fetch_data !== XS'(104)) begin
      bad++; $display("FAIL fetch_g2: got %0d want 104", fetch_data);
    end
  endtask

  task automatic test_pause_step();
    int starts;
    starts = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (gen_start === 1'b1) starts++;
    end
    total++;
    if (starts !== 0) begin
      bad++; $display("FAIL paused_idle: got %0d want 0", starts);
    end
    gen_done = 1'b1;
    frame_end = 1'b1;
    tick();
    gen_done = 1'b0;
    frame_end = 1'b0;
    tick();
    tick();
    total++;
    if ({front, gen_count} !== {1'b0, 16'd2}) begin
      bad++;
      $display("FAIL done_idle: got %b/%0d want 0/2", front, gen_count);
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    total++;
    if (gen_start !== 1'b1) begin
      bad++; $display("FAIL step_start: got %b want 1", gen_start);
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    starts = (gen_start === 1'b1) ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (gen_start === 1'b1) starts++;
    end
    total++;
    if (starts !== 0) begin
      bad++; $display("FAIL step_in_run: got %0d want 0", starts);
    end
    gen_done = 1'b1;
    tick();
    gen_done = 1'b0;
    tick();
    tick();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    tick();
    total++;
    if ({front, gen_count} !== {1'b1, 16'd3}) begin
      bad++;
      $display("FAIL step_swap: got %b/%0d want 1/3", front, gen_count);
    end
    starts = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (gen_start === 1'b1) starts++;
    end
    total++;
    if (starts !== 0) begin
      bad++; $display("FAIL stay_idle: got %0d want 0", starts);
    end
  endtask

  task automatic test_oob();
    step = 1'b1;
    tick();
    step = 1'b0;
    total++;
    if (gen_start !== 1'b1) begin
      bad++; $display("FAIL oob_start: got %b want 1", gen_start);
    end
    wr_addr = 10'd720;
    wr_data = XS'(55);
    wr_en = 1'b1;
    #1;
    total++;
    if ({ifa.wea, ifb.wea} !== 2'b00) begin
      bad++; $display("FAIL oob_wea: got %b want 00", {ifa.wea, ifb.wea});
    end
    tick();
    total++;
    if (wr_oob !== 1'b1) begin
      bad++; $display("FAIL oob_set: got %b want 1", wr_oob);
    end
    wr_addr = 10'd719;
    #1;
    total++;
    if (ifa.wea !== 1'b1) begin
      bad++; $display("FAIL edge_wea: got %b want 1", ifa.wea);
    end
    tick();
    wr_en = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (wr_oob !== 1'b1) begin
      bad++; $display("FAIL oob_sticky: got %b want 1", wr_oob);
    end
  endtask

  task automatic test_rst_mid_run();
    total++;
    if (front !== 1'b1) begin
      bad++; $display("FAIL pre_rst_front: got %b want 1", front);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({front, gen_count, wr_oob} !== {1'b0, 16'd0, 1'b0}) begin
      bad++;
      $display("FAIL rst_run: got %b/%0d/%b want 0/0/0",
               front, gen_count, wr_oob);
    end
    wr_addr = 10'd1;
    wr_en = 1'b1;
    #1;
    total++;
    if ({ifa.wea, ifb.wea} !== 2'b00) begin
      bad++; $display("FAIL rst_idle_we: got %b want 00", {ifa.wea, ifb.wea});
    end
    tick();
    wr_en = 1'b0;
    total++;
    if (gen_start !== 1'b0) begin
      bad++; $display("FAIL rst_no_start: got %b want 0", gen_start);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_same_cycle();
    test_pause_step();
    test_oob();
    test_rst_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gen_buffer_controller.md
# gen_buffer_controller

Ping-pong bank controller for the two row-wide cell BRAMs (bank A, bank B) between the next-state compute engine and the video output path. Unlike a bare mode-driven mux, it owns the front/back bank select, sequences generations with a start/done handshake, and swaps banks only at a video frame boundary. Pause and single-step are supported without tearing. Sits between the line buffer / parallel next-state engine, the video row reader, and both true-dual-port BRAMs.

## Interface
- X_SIZE, 1280, cells per row (BRAM data width)
- Y_SIZE, 720, rows per frame (valid addresses 0..Y_SIZE-1)
- Y_WIDTH, 10, row address width
- GEN_WIDTH, 16, generation counter width
- clk  in  1  system clock
- rst  in  1  reset, synchronous and active-high
- pause  in  1  level; high = no new generation is started
- step  in  1  1-cycle pulse; while paused, runs exactly one generation
- frame_end  in  1  1-cycle pulse from video timing at end of last active line
- gen_start  out  1  1-cycle pulse: compute engine begins a generation
- gen_done  in  1  1-cycle pulse: engine has written all rows
- fetch_addr  in  Y_WIDTH  line-buffer read row
- fetch_data  out  X_SIZE  front-bank port-a read data
- wr_addr  in  Y_WIDTH  next-state write row
- wr_data  in  X_SIZE  next-state row result
- wr_en  in  1  next-state write strobe
- vid_addr  in  Y_WIDTH  video row address
- vid_data  out  X_SIZE  front-bank port-b read data
- bram_{a,b}_addra / dina / wea, bram_{a,b}_addrb / dinb / web  out  widths per BRAM port
- bram_{a,b}_douta, bram_{a,b}_doutb  in  X_SIZE  BRAM read data
- front  out  1  0 = bank A displayed/read, 1 = bank B
- gen_count  out  GEN_WIDTH  completed (swapped) generations, wraps modulo 2^GEN_WIDTH
- wr_oob  out  1  sticky: a write with wr_addr >= Y_SIZE was dropped

## Operation
- States: IDLE, RUN, WAIT_SWAP, SWAP.
- IDLE: if !pause, or pause && step -> RUN, asserting gen_start for one cycle on the transition. step ignored when !pause (free-running anyway).
- RUN: back-bank writes enabled. gen_done && frame_end same cycle -> SWAP; gen_done alone -> WAIT_SWAP.
- WAIT_SWAP: writes to back bank blocked; on frame_end -> SWAP.
- SWAP: one cycle; front toggles, gen_count increments; -> IDLE (start decision re-evaluated there, so free-run restarts one cycle later).
- pause asserted mid-RUN: current generation completes and swaps; no new start.
- Routing (combinational from front): front bank port a = fetch_addr, wea = 0; back bank port a = wr_addr, dina = wr_data, wea = wr_en && state==RUN && wr_addr < Y_SIZE; both banks port b addr = vid_addr, web = 0, dinb = 0; fetch_data/vid_data select front bank douta/doutb.
- wr_en with wr_addr >= Y_SIZE: write suppressed, wr_oob set until rst.
- gen_done outside RUN: ignored. step outside IDLE: ignored (not queued).

## Timing
- Reset values: state IDLE, front 0, gen_start 0, gen_count 0, wr_oob 0; all bram we 0.
- gen_start asserted in the cycle after IDLE sees the start condition; engine may write from the next cycle.
- Read data latency = BRAM latency; controller adds zero cycles (pure mux on addr/data paths).
- front changes on the clock edge leaving SWAP; video sees new bank from the first row after frame_end, never mid-frame.
- Minimum generation-to-generation period: gen_done to next gen_start >= 3 cycles (WAIT_SWAP/SWAP, IDLE).
- rst mid-RUN: generation abandoned, front returns to 0 regardless of prior value.

## Structure
- Shared package gol_buf_pkg: state enum (IDLE, RUN, WAIT_SWAP, SWAP), BANK_A=0 / BANK_B=1 constants.
- Sub-module bank_router: purely combinational port steering given front and write-enable qualifier; FSM, counters and flags stay in the top.

## Test plan
- Reset, pause=0: gen_start at cycle 1; writes rows 0..719 with pattern row index, gen_done, frame_end 10 cycles later -> front=1 after SWAP, gen_count=1, vid_data(row 5) = 5.
- Writes during WAIT_SWAP with wr_en=1 -> back-bank wea stays 0, BRAM contents unchanged.
- pause=1, step pulse -> exactly one gen_start; second step during RUN ignored; after swap stays IDLE, gen_count=1.
- gen_done and frame_end same cycle -> SWAP next cycle, front toggles, no extra frame wait.
- wr_addr=720, wr_en=1 in RUN -> no wea, wr_oob=1 and stays set; clears only on rst.
- rst asserted mid-RUN with front=1 -> next cycle front=0, state IDLE, gen_count=0.
